// File: rtl/period_meter.sv
// Measures period and high time of a slow toggling input in CLOCK cycles.
// Captures on each synchronized rising edge after the first; sticky TIMEOUT on counter saturation.
module period_meter #(
    parameter int unsigned WIDTH       = 24,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             SIG_IN,
    input  logic             ENABLE,
    output logic [WIDTH-1:0] PERIOD,
    output logic [WIDTH-1:0] HIGH_TIME,
    output logic             VALID,
    output logic             TIMEOUT
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d;
    logic                   rise;
    logic [WIDTH-1:0]       cnt;
    logic [WIDTH-1:0]       hcnt;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], SIG_IN};
            s_d    <= s;
        end
    end

    // The first rise after arming only starts the count; captures happen on later rises.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            cnt       <= '0;
            hcnt      <= '0;
            PERIOD    <= '0;
            HIGH_TIME <= '0;
            VALID     <= 1'b0;
            TIMEOUT   <= 1'b0;
        end else begin
            VALID <= 1'b0;
            if (!ENABLE) begin
                state   <= IDLE;
                cnt     <= '0;
                hcnt    <= '0;
                TIMEOUT <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt   <= '0;
                        hcnt  <= '0;
                        state <= ARM;
                    end
                    ARM: begin
                        if (rise) begin
                            cnt   <= CNT_ONE;
                            hcnt  <= CNT_ONE;
                            state <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        // A rise takes priority over saturation in the same cycle.
                        if (rise) begin
                            PERIOD    <= cnt;
                            HIGH_TIME <= hcnt;
                            VALID     <= 1'b1;
                            TIMEOUT   <= 1'b0;
                            cnt       <= CNT_ONE;
                            hcnt      <= CNT_ONE;
                        end else if (cnt == CNT_MAX) begin
                            TIMEOUT <= 1'b1;
                            cnt     <= '0;
                            hcnt    <= '0;
                            state   <= ARM;
                        end else begin
                            cnt  <= cnt + CNT_ONE;
                            hcnt <= hcnt + WIDTH'(s);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: a time-based reference model predicts captures,
// a negedge monitor compares VALID/PERIOD/HIGH_TIME/TIMEOUT against it.
module tb_period_meter;

    localparam int W    = 8;
    localparam int S    = 2;
    localparam int MAXV = (1 << W) - 1;

    logic         CLOCK  = 1'b0;
    logic         RESET  = 1'b1;
    logic         SIG_IN = 1'b0;
    logic         ENABLE = 1'b0;
    logic [W-1:0] PERIOD;
    logic [W-1:0] HIGH_TIME;
    logic         VALID;
    logic         TIMEOUT;

    period_meter #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .SIG_IN   (SIG_IN),
        .ENABLE   (ENABLE),
        .PERIOD   (PERIOD),
        .HIGH_TIME(HIGH_TIME),
        .VALID    (VALID),
        .TIMEOUT  (TIMEOUT)
    );

    always #5 CLOCK = ~CLOCK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: per-edge input history and the edge index of the reference rise.
    bit hist [0:29999];
    int e        = 0;
    bit armed_ok = 0;
    int t0       = -1;
    bit exp_to   = 0;
    int exp_p    = 0;
    int exp_h    = 0;
    int qp[$];
    int qh[$];
    bit in_reset = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, act, exp, e, $time);
        end
    endtask

    // The measurement logic sees the input value driven for edge c at edge c+S.
    task automatic model_step(input bit en);
        bit rise;
        int h;
        rise = (e >= S + 1) && hist[e-S] && !hist[e-S-1];
        if (!en) begin
            armed_ok = 0;
            t0       = -1;
            exp_to   = 0;
        end else if (!armed_ok) begin
            armed_ok = 1;
            t0       = -1;
        end else if (rise) begin
            if (t0 >= 0) begin
                h = 0;
                for (int c = t0; c < e; c++) h += hist[c-S];
                exp_p  = e - t0;
                exp_h  = h;
                exp_to = 0;
                qp.push_back(exp_p);
                qh.push_back(exp_h);
            end
            t0 = e;
        end else if (t0 >= 0 && (e - t0) == MAXV) begin
            exp_to = 1;
            t0     = -1;
        end
    endtask

    task automatic tick(input bit sv, input bit ev);
        @(negedge CLOCK);
        SIG_IN = sv;
        ENABLE = ev;
        @(posedge CLOCK);
        hist[e] = sv;
        model_step(ev);
        e++;
    endtask

    task automatic wave(input int p, input int h, input int n);
        for (int k = 0; k < n; k++)
            for (int c = 0; c < p; c++) tick(c < h, 1'b1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_period"}, 32'(PERIOD), 32'd0);
        check({tag, "_high"}, 32'(HIGH_TIME), 32'd0);
        check({tag, "_valid"}, 32'(VALID), 32'd0);
        check({tag, "_timeout"}, 32'(TIMEOUT), 32'd0);
    endtask

    // Release between edges, then account for the edge that follows release.
    task automatic release_reset();
        @(negedge CLOCK);
        #2 RESET = 1'b0;
        in_reset = 0;
        @(posedge CLOCK);
        hist[e] = SIG_IN;
        model_step(ENABLE);
        e++;
    endtask

    task automatic async_reset();
        @(negedge CLOCK);
        #2 RESET = 1'b1;
        in_reset = 1;
        #1 check_zero_outputs("async_reset");
        armed_ok = 0;
        t0       = -1;
        exp_to   = 0;
        exp_p    = 0;
        exp_h    = 0;
        qp.delete();
        qh.delete();
        release_reset();
    endtask

    always @(negedge CLOCK) begin
        if (!in_reset) begin
            check("valid", 32'(VALID), 32'(qp.size() != 0));
            if (qp.size() != 0) begin
                if (VALID) begin
                    check("cap_period", 32'(PERIOD), 32'(qp[0]));
                    check("cap_high", 32'(HIGH_TIME), 32'(qh[0]));
                end
                void'(qp.pop_front());
                void'(qh.pop_front());
            end
            check("timeout", 32'(TIMEOUT), 32'(exp_to));
            check("hold_period", 32'(PERIOD), 32'(exp_p));
            check("hold_high", 32'(HIGH_TIME), 32'(exp_h));
        end
    end

    initial begin
        int p, h, d0, dl;
        bit drop;

        repeat (3) @(negedge CLOCK);
        #1 check_zero_outputs("reset");
        release_reset();

        // Square wave 16/8, then duty-cycle change at period 10.
        wave(16, 8, 6);
        wave(10, 3, 4);
        wave(10, 7, 4);

        // Single rise then held low long enough to saturate, then recover.
        repeat (5) tick(1'b1, 1'b1);
        repeat (300) tick(1'b0, 1'b1);
        wave(20, 10, 4);

        // Minimum period.
        wave(4, 2, 6);

        // Drop ENABLE mid-period, then re-enable.
        wave(12, 5, 3);
        repeat (4) tick(1'b1, 1'b1);
        repeat (10) tick(1'b0, 1'b0);
        wave(12, 5, 4);

        // ENABLE falls exactly on the edge where a rise is detected.
        repeat (6) tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        repeat (S - 1) tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        repeat (4) tick(1'b0, 1'b1);
        wave(9, 4, 4);

        // Randomized periods, duty cycles and enable drops.
        for (int k = 0; k < 40; k++) begin
            p    = $urandom_range(60, 2);
            h    = $urandom_range(p - 1, 1);
            drop = ($urandom_range(7, 0) == 0);
            d0   = $urandom_range(p - 1, 0);
            dl   = $urandom_range(6, 1);
            for (int c = 0; c < p; c++)
                tick(c < h, !(drop && c >= d0 && c < d0 + dl));
        end

        // Asynchronous reset in the middle of a measurement, then resume.
        wave(14, 6, 2);
        repeat (S + 3) tick(1'b0, 1'b1);
        async_reset();
        wave(14, 6, 3);
        for (int k = 0; k < 10; k++) begin
            p = $urandom_range(40, 2);
            h = $urandom_range(p - 1, 1);
            wave(p, h, 1);
        end
        repeat (S + 3) tick(1'b0, 1'b1);

        check("queue_drained", 32'(qp.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
